// File: rtl/ar_burst_reg.sv
// ar_burst_reg: parametrised address register for the basic-computer datapath.
// It supports load, increment/decrement by STEP, clear, and an autonomous burst
// that steps AR brLEN times with a busy/done handshake.
//
// Ports:
//   CLK      clock; all state changes on the rising edge
//   RST      synchronous active-high reset
//   arCLR    clear AR and arCOUT (also aborts a burst)
//   arLD     load AR from inAR (truncated or zero-extended to AW)
//   inAR     load data
//   arINR    AR += STEP (held if arDCR is also high)
//   arDCR    AR -= STEP (held if arINR is also high)
//   brSTART  start a burst of brLEN increments from the current AR
//   brLEN    burst step count (0 produces only a done pulse)
//   AR       address register
//   arCOUT   carry/borrow of the last step; cleared by load and clear
//   brBUSY   burst in progress
//   brDONE   one-cycle pulse when a burst completes
//
// Optional feature, macro AR_BOUND_EN:
//   It adds arLIM (inclusive upper bound) and arOOB (sticky out-of-bound flag).
//   A burst step that would pass arLIM, or would wrap, ends the burst early
//   and leaves AR unchanged.
module ar_burst_reg #(
  parameter int AW    = 12,
  parameter int IN_W  = 16,
  parameter int LEN_W = 8,
  parameter int STEP  = 1,
  parameter int SAT   = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             arCLR,
  input  logic             arLD,
  input  logic [IN_W-1:0]  inAR,
  input  logic             arINR,
  input  logic             arDCR,
  input  logic             brSTART,
  input  logic [LEN_W-1:0] brLEN,
  output logic [AW-1:0]    AR,
  output logic             arCOUT,
  output logic             brBUSY,
  output logic             brDONE
`ifdef AR_BOUND_EN
  ,
  input  logic [AW-1:0]    arLIM,
  output logic             arOOB
`endif
);

  localparam logic [AW:0] STEP_X = (AW+1)'(STEP);
  localparam bit          SAT_ON = (SAT != 32'sd0);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Increment helper. It returns {carry, value} and applies saturation when enabled.
  function automatic logic [AW:0] inc_step(input logic [AW-1:0] a);
    logic [AW:0] sum;
    sum = {1'b0, a} + STEP_X;
    if (SAT_ON && sum[AW]) begin
      inc_step = {1'b1, {AW{1'b1}}};
    end else begin
      inc_step = sum;
    end
  endfunction

  // Decrement helper. It returns {borrow, value}. The MSB of the AW+1 bit
  // difference is the borrow, because STEP < 2**AW.
  function automatic logic [AW:0] dec_step(input logic [AW-1:0] a);
    logic [AW:0] diff;
    diff = {1'b0, a} - STEP_X;
    if (SAT_ON && diff[AW]) begin
      dec_step = {1'b1, {AW{1'b0}}};
    end else begin
      dec_step = diff;
    end
  endfunction

  state_t           state_r, state_nxt_s;
  logic [AW-1:0]    ar_r, ar_nxt_s;
  logic             cout_r, cout_nxt_s;
  logic [LEN_W-1:0] cnt_r, cnt_nxt_s;
  logic             done_r, done_nxt_s;
  logic [AW:0]      inc_res_s, dec_res_s;
  logic [AW-1:0]    ld_val_s;

  assign inc_res_s = inc_step(ar_r);
  assign dec_res_s = dec_step(ar_r);
  assign ld_val_s  = AW'(inAR);

`ifdef AR_BOUND_EN
  logic        oob_r, oob_nxt_s;
  logic [AW:0] raw_sum_s;
  logic        oob_hit_s;
  // The bound check uses the unsaturated sum, so a wrap counts as out of bound.
  assign raw_sum_s = {1'b0, ar_r} + STEP_X;
  assign oob_hit_s = raw_sum_s[AW] | (raw_sum_s[AW-1:0] > arLIM);
  assign arOOB     = oob_r;
`endif

  assign AR     = ar_r;
  assign arCOUT = cout_r;
  assign brBUSY = (state_r == RUN);
  assign brDONE = done_r;

  // Next-state logic: command priority while idle, and burst stepping while running.
  always_comb begin
    state_nxt_s = state_r;
    ar_nxt_s    = ar_r;
    cout_nxt_s  = cout_r;
    cnt_nxt_s   = cnt_r;
    done_nxt_s  = 1'b0;
`ifdef AR_BOUND_EN
    oob_nxt_s   = oob_r;
`endif
    case (state_r)
      IDLE: begin
        if (arCLR) begin
          ar_nxt_s   = {AW{1'b0}};
          cout_nxt_s = 1'b0;
`ifdef AR_BOUND_EN
          oob_nxt_s  = 1'b0;
`endif
        end else if (arLD) begin
          ar_nxt_s   = ld_val_s;
          cout_nxt_s = 1'b0;
`ifdef AR_BOUND_EN
          oob_nxt_s  = 1'b0;
`endif
        end else if (brSTART) begin
`ifdef AR_BOUND_EN
          oob_nxt_s = 1'b0;
`endif
          if (brLEN == {LEN_W{1'b0}}) begin
            done_nxt_s = 1'b1;
          end else begin
            state_nxt_s = RUN;
            cnt_nxt_s   = brLEN;
          end
        end else if (arINR ^ arDCR) begin
          if (arINR) begin
            {cout_nxt_s, ar_nxt_s} = inc_res_s;
          end else begin
            {cout_nxt_s, ar_nxt_s} = dec_res_s;
          end
        end else begin
          // No command, or arINR and arDCR together: hold the register.
          ar_nxt_s = ar_r;
        end
      end
      RUN: begin
        if (arCLR) begin
          // An abort returns to IDLE without a done pulse.
          state_nxt_s = IDLE;
          ar_nxt_s    = {AW{1'b0}};
          cout_nxt_s  = 1'b0;
          cnt_nxt_s   = {LEN_W{1'b0}};
`ifdef AR_BOUND_EN
          oob_nxt_s   = 1'b0;
        end else if (oob_hit_s) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = {LEN_W{1'b0}};
          done_nxt_s  = 1'b1;
          oob_nxt_s   = 1'b1;
`endif
        end else begin
          {cout_nxt_s, ar_nxt_s} = inc_res_s;
          cnt_nxt_s = cnt_r - LEN_W'(1'b1);
          if (cnt_r == LEN_W'(1'b1)) begin
            state_nxt_s = IDLE;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = RUN;
          end
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {LEN_W{1'b0}};
      end
    endcase
  end

  // State and datapath registers, with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
      ar_r    <= {AW{1'b0}};
      cout_r  <= 1'b0;
      cnt_r   <= {LEN_W{1'b0}};
      done_r  <= 1'b0;
`ifdef AR_BOUND_EN
      oob_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      ar_r    <= ar_nxt_s;
      cout_r  <= cout_nxt_s;
      cnt_r   <= cnt_nxt_s;
      done_r  <= done_nxt_s;
`ifdef AR_BOUND_EN
      oob_r   <= oob_nxt_s;
`endif
    end
  end

endmodule

// File: tb/tb_ar_burst_reg.sv
// tb_ar_burst_reg: directed self-checking bench for ar_burst_reg.
// It runs a wrap instance (SAT=0) and a saturating instance (SAT=1) from the same inputs.
// When built with AR_BOUND_EN, it also checks the early end of a burst at the bound.
module tb_ar_burst_reg;

  logic        CLK = 1'b0;
  logic        RST, arCLR, arLD, arINR, arDCR, brSTART;
  logic [15:0] inAR;
  logic [7:0]  brLEN;
  logic [11:0] ar_w, ar_s;
  logic        cout_w, cout_s, busy_w, busy_s, done_w, done_s;
`ifdef AR_BOUND_EN
  logic [11:0] arLIM;
  logic        oob_w, oob_s;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ar_burst_reg dut (
    .CLK(CLK), .RST(RST), .arCLR(arCLR), .arLD(arLD), .inAR(inAR),
    .arINR(arINR), .arDCR(arDCR), .brSTART(brSTART), .brLEN(brLEN),
    .AR(ar_w), .arCOUT(cout_w), .brBUSY(busy_w), .brDONE(done_w)
`ifdef AR_BOUND_EN
    , .arLIM(arLIM), .arOOB(oob_w)
`endif
  );

  ar_burst_reg #(.SAT(1)) dut_sat (
    .CLK(CLK), .RST(RST), .arCLR(arCLR), .arLD(arLD), .inAR(inAR),
    .arINR(arINR), .arDCR(arDCR), .brSTART(brSTART), .brLEN(brLEN),
    .AR(ar_s), .arCOUT(cout_s), .brBUSY(busy_s), .brDONE(done_s)
`ifdef AR_BOUND_EN
    , .arLIM(arLIM), .arOOB(oob_s)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [15:0] v);
    inAR = v; arLD = 1'b1; tick(); arLD = 1'b0;
  endtask

  initial begin
    RST = 1'b1; arCLR = 1'b0; arLD = 1'b0; arINR = 1'b0; arDCR = 1'b0;
    brSTART = 1'b0; inAR = 16'h0000; brLEN = 8'd0;
`ifdef AR_BOUND_EN
    arLIM = 12'hFFF;
`endif
    tick(); tick();
    RST = 1'b0;
    chk("rst_ar", ar_w, 12'h000);
    chk("rst_cout", cout_w, 1'b0);
    chk("rst_busy", busy_w, 1'b0);
    chk("rst_done", done_w, 1'b0);

    // Load truncates the 16-bit bus to the 12-bit register.
    load(16'hABCD);
    chk("ld_ar", ar_w, 12'hBCD);
    chk("ld_cout", cout_w, 1'b0);
    chk("ld_busy", busy_w, 1'b0);

    // Increment at all-ones: wrap versus saturate.
    load(16'h0FFF);
    arINR = 1'b1; tick(); arINR = 1'b0;
    chk("inc_wrap_ar", ar_w, 12'h000);
    chk("inc_wrap_cout", cout_w, 1'b1);
    chk("inc_sat_ar", ar_s, 12'hFFF);
    chk("inc_sat_cout", cout_s, 1'b1);
    tick();
    chk("cout_hold", cout_w, 1'b1);

    // Decrement at zero, then arINR and arDCR together hold the register.
    load(16'h0000);
    chk("ld_clr_cout", cout_w, 1'b0);
    arDCR = 1'b1; tick(); arDCR = 1'b0;
    chk("dec_wrap_ar", ar_w, 12'hFFF);
    chk("dec_wrap_cout", cout_w, 1'b1);
    chk("dec_sat_ar", ar_s, 12'h000);
    chk("dec_sat_cout", cout_s, 1'b1);
    arINR = 1'b1; arDCR = 1'b1; tick(); arINR = 1'b0; arDCR = 1'b0;
    chk("incdec_hold", ar_w, 12'hFFF);

    // Plain increment and decrement, with no carry.
    load(16'h0010);
    arINR = 1'b1; tick(); arINR = 1'b0;
    chk("inc_ar", ar_w, 12'h011);
    chk("inc_cout", cout_w, 1'b0);
    arDCR = 1'b1; tick(); tick(); arDCR = 1'b0;
    chk("dec_ar", ar_w, 12'h00F);

    // Clear.
    arCLR = 1'b1; tick(); arCLR = 1'b0;
    chk("clr_ar", ar_w, 12'h000);

    // Burst of 4 from 0x100. A load during the burst is ignored.
    load(16'h0100);
    brSTART = 1'b1; brLEN = 8'd4; tick(); brSTART = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("br_busy", busy_w, 1'b1);
      chk("br_ar", ar_w, 12'h100 + i);
      chk("br_nodone", done_w, 1'b0);
      if (i == 1) begin inAR = 16'h0555; arLD = 1'b1; end
      tick();
      arLD = 1'b0;
    end
    chk("br_done", done_w, 1'b1);
    chk("br_end_ar", ar_w, 12'h104);
    chk("br_end_busy", busy_w, 1'b0);

    // A start on the done cycle is accepted.
    brSTART = 1'b1; brLEN = 8'd1; tick(); brSTART = 1'b0;
    chk("br2_busy", busy_w, 1'b1);
    chk("br2_nodone", done_w, 1'b0);
    tick();
    chk("br2_done", done_w, 1'b1);
    chk("br2_ar", ar_w, 12'h105);
    tick();
    chk("br2_pulse", done_w, 1'b0);

    // A zero-length burst produces only the done pulse.
    brSTART = 1'b1; brLEN = 8'd0; tick(); brSTART = 1'b0;
    chk("br0_done", done_w, 1'b1);
    chk("br0_busy", busy_w, 1'b0);
    chk("br0_ar", ar_w, 12'h105);

    // Abort with arCLR on the second busy cycle.
    load(16'h0100);
    brSTART = 1'b1; brLEN = 8'd8; tick(); brSTART = 1'b0;
    tick();
    chk("ab_busy2", busy_w, 1'b1);
    arCLR = 1'b1; tick(); arCLR = 1'b0;
    chk("ab_ar", ar_w, 12'h000);
    chk("ab_busy", busy_w, 1'b0);
    chk("ab_done", done_w, 1'b0);
    tick();
    chk("ab_nodone", done_w, 1'b0);

`ifndef AR_BOUND_EN
    // A burst that crosses the top of the range: wrap versus saturate.
    load(16'h0FFE);
    brSTART = 1'b1; brLEN = 8'd3; tick(); brSTART = 1'b0;
    tick(); tick(); tick();
    chk("brw_done", done_w, 1'b1);
    chk("brw_ar", ar_w, 12'h001);
    chk("brw_cout", cout_w, 1'b0);
    chk("brs_ar", ar_s, 12'hFFF);
    chk("brs_cout", cout_s, 1'b1);
    chk("brs_done", done_s, 1'b1);
`else
    // The bound ends the burst early.
    arLIM = 12'h102;
    load(16'h0100);
    brSTART = 1'b1; brLEN = 8'd8; tick(); brSTART = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bd_busy", busy_w, 1'b1);
      chk("bd_ar", ar_w, 12'h100 + i);
      tick();
    end
    chk("bd_done", done_w, 1'b1);
    chk("bd_end_busy", busy_w, 1'b0);
    chk("bd_end_ar", ar_w, 12'h102);
    chk("bd_oob", oob_w, 1'b1);
    tick();
    chk("bd_oob_sticky", oob_w, 1'b1);
    load(16'h0000);
    chk("bd_oob_clr", oob_w, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
